// File: rtl/up_down_counter.sv
// Binary up/down counter with a one-shot preload from data on the first
// clock edge after reset release; wraps modulo 2^WIDTH in both directions.
module up_down_counter #(
  parameter int WIDTH = 8
) (
  output logic [WIDTH-1:0] out,
  input  logic             up_down,
  input  logic             clk,
  input  logic [WIDTH-1:0] data,
  input  logic             reset
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(1);

  logic [WIDTH-1:0] count;
  logic             load_pend;

  // load_pend marks the first edge after reset, which preloads instead of counting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      load_pend <= 1'b1;
    end else if (load_pend) begin
      count     <= data;
      load_pend <= 1'b0;
    end else if (up_down) begin
      count <= count + STEP;
    end else begin
      count <= count - STEP;
    end
  end

  assign out = count;

endmodule

// File: tb/tb_up_down_counter.sv
// Self-checking bench for up_down_counter: a reference model pushes the expected
// count per edge into a queue, and a checker pops and compares after each edge.
module tb_up_down_counter;

  localparam int WIDTH = 8;

  logic [WIDTH-1:0] out;
  logic             up_down;
  logic             clk;
  logic [WIDTH-1:0] data;
  logic             reset;

  up_down_counter #(.WIDTH(WIDTH)) dut (
    .out     (out),
    .up_down (up_down),
    .clk     (clk),
    .data    (data),
    .reset   (reset)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: independent of the DUT, steps on the same edges.
  logic [WIDTH-1:0] m_cnt;
  logic             m_pend;
  logic [WIDTH-1:0] exp_q[$];

  function automatic logic [WIDTH-1:0] model_next(input logic [WIDTH-1:0] c, input logic p,
                                                  input logic ud, input logic [WIDTH-1:0] d);
    int unsigned v;
    if (p) return d;
    v = ud ? (int'(c) + 1) % (1 << WIDTH) : (int'(c) + (1 << WIDTH) - 1) % (1 << WIDTH);
    return WIDTH'(v);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt  <= '0;
      m_pend <= 1'b1;
    end else begin
      exp_q.push_back(model_next(m_cnt, m_pend, up_down, data));
      m_cnt  <= model_next(m_cnt, m_pend, up_down, data);
      m_pend <= 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (reset && exp_q.size() > 0) chk("sb", out, exp_q.pop_front());
  end

  task automatic edge_check(input string tag, input logic [WIDTH-1:0] exp);
    @(posedge clk);
    #2;
    chk(tag, out, exp);
  endtask

  task automatic restart(input logic [WIDTH-1:0] d, input logic ud);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_low", out, '0);
    @(negedge clk);
    data    = d;
    up_down = ud;
    reset   = 1'b1;
  endtask

  logic [WIDTH-1:0] seq_down[8] = '{8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'hFF, 8'hFE};
  logic [WIDTH-1:0] seq_wrap[5] = '{8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01};

  initial begin
    // Test 1: reset, load 0, count up to t=500
    reset   = 1'b0;
    data    = '0;
    up_down = 1'b1;
    #1;
    chk("rst_init", out, '0);
    @(negedge clk);
    reset = 1'b1;
    repeat (24) @(negedge clk);
    chk("t500", out, 8'd23);

    // Test 6: reset held across edges with varying inputs
    reset = 1'b0;
    #1;
    chk("hold_rst0", out, '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      up_down = 1'($urandom);
      data    = WIDTH'($urandom);
      @(posedge clk);
      #1;
      chk("hold_rst", out, '0);
    end

    // Test 2: preload 5, count down through zero
    @(negedge clk);
    data    = 8'h05;
    up_down = 1'b0;
    reset   = 1'b1;
    for (int i = 0; i < 8; i++) edge_check("down", seq_down[i]);

    // Test 3: up wrap
    restart(8'hFD, 1'b1);
    for (int i = 0; i < 5; i++) edge_check("upwrap", seq_wrap[i]);

    // Test 4: direction toggle, data ignored after load
    restart(8'd10, 1'b1);
    edge_check("tog_load", 8'd10);
    @(negedge clk);
    data = 8'd99;
    edge_check("tog_up1", 8'd11);
    edge_check("tog_up2", 8'd12);
    edge_check("tog_up3", 8'd13);
    @(negedge clk);
    up_down = 1'b0;
    edge_check("tog_dn1", 8'd12);
    edge_check("tog_dn2", 8'd11);

    // Test 5: async reset mid-count, then reload
    restart(8'h3E, 1'b1);
    edge_check("a_ld", 8'h3E);
    edge_check("a_3f", 8'h3F);
    edge_check("a_40", 8'h40);
    #3;
    reset = 1'b0;
    #1;
    chk("async_rst", out, '0);
    @(negedge clk);
    data  = 8'h20;
    reset = 1'b1;
    edge_check("a_reload", 8'h20);
    edge_check("a_21", 8'h21);
    edge_check("a_22", 8'h22);

    // Load of all-ones then count up wraps to zero
    restart(8'hFF, 1'b1);
    edge_check("ff_ld", 8'hFF);
    edge_check("ff_wrap", 8'h00);

    @(negedge clk);
    chk("sb_drain", WIDTH'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
